// File: rtl/frog_hazard_monitor_pkg.sv
// Shared types and board geometry for the frog hazard monitor.
// Build option FROG_GRACE_EN enables post-respawn grace in the monitor.
package frog_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    localparam logic [3:0] START_ROW = 4'd0;
    localparam logic [3:0] GOAL_ROW  = 4'd15;
    localparam logic [3:0] SPAWN_X   = 4'd7;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HIT  = 2'd1,
        GOAL = 2'd2,
        OVER = 2'd3
    } mon_state_t;

endpackage

// File: rtl/frog_hazard_monitor_if.sv
// Board-state and game-event bundle between row generators/frog mover and the monitor.
// master drives the board and frog position, slave (the monitor) drives the events.
interface frog_hazard_monitor_if #(
    parameter int SCORE_W = 8
);
    import frog_pkg::*;

    logic [ROWS-1:0][COLS-1:0] row_pixels;
    logic [ROWS-1:0]           river_rows;
    logic [3:0]                frog_x;
    logic [3:0]                frog_y;

    logic                      hit;
    logic                      goal;
    logic                      respawn;
    logic                      frog_blank;
    logic [2:0]                lives;
    logic [SCORE_W-1:0]        score;
    logic                      game_over;

    modport master (
        output row_pixels, river_rows, frog_x, frog_y,
        input  hit, goal, respawn, frog_blank, lives, score, game_over
    );

    modport slave (
        input  row_pixels, river_rows, frog_x, frog_y,
        output hit, goal, respawn, frog_blank, lives, score, game_over
    );

endinterface

// File: rtl/frog_hazard_monitor_flash_timer.sv
// Loadable down-counter: load sets all-ones, counts to zero, done pulses for the zero cycle.
// Runs for exactly 2^W cycles after a load; a load while running restarts it.
module flash_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] r_cnt;
    logic         r_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_cnt    <= '1;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

    assign count = r_cnt;
    assign done  = r_active && (r_cnt == '0);

endmodule

// File: rtl/frog_hazard_monitor.sv
// Frog hit/drown/goal detection, lives, score, hit-flash and game-over tracking.
// Optional macro FROG_GRACE_EN adds a danger-masking grace period after each respawn.
module frog_hazard_monitor
    import frog_pkg::*;
#(
    parameter int LIVES   = 3,
    parameter int FLASH_W = 24,
    parameter int SCORE_W = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    frog_hazard_monitor_if.slave bus
);

    mon_state_t         r_state;
    mon_state_t         w_state_nxt;

    logic               r_hit;
    logic               r_goal;
    logic               r_respawn;
    logic [2:0]         r_lives;
    logic [SCORE_W-1:0] r_score;

    logic               w_hit_nxt;
    logic               w_goal_nxt;
    logic               w_respawn_nxt;
    logic [2:0]         w_lives_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               w_blank;

    logic               w_cell;
    logic               w_at_goal;
    logic               w_danger;
    logic               w_risk;

    logic [FLASH_W-1:0] w_flash_cnt;
    logic               w_flash_done;
    logic               w_grace_on;
    logic               w_grace_blank;

    assign w_cell    = bus.row_pixels[bus.frog_y][bus.frog_x];
    assign w_at_goal = (bus.frog_y == GOAL_ROW);
    // On a river row a lit pixel is a log, so it is the dark cells that drown the frog.
    assign w_danger  = (bus.frog_y != START_ROW) && !w_at_goal &&
                       (bus.river_rows[bus.frog_y] ? !w_cell : w_cell);
    assign w_risk    = w_danger && !w_grace_on;

    flash_timer #(.W(FLASH_W)) u_flash (
        .clock (clock),
        .reset (reset),
        .load  (w_hit_nxt),
        .count (w_flash_cnt),
        .done  (w_flash_done)
    );

`ifdef FROG_GRACE_EN
    logic [FLASH_W-2:0] w_grace_cnt;
    logic               w_grace_done;

    flash_timer #(.W(FLASH_W-1)) u_grace (
        .clock (clock),
        .reset (reset),
        .load  (w_respawn_nxt),
        .count (w_grace_cnt),
        .done  (w_grace_done)
    );

    assign w_grace_on    = (w_grace_cnt != '0) || w_grace_done;
    assign w_grace_blank = w_grace_on && w_grace_cnt[FLASH_W-3];
`else
    assign w_grace_on    = 1'b0;
    assign w_grace_blank = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RUN;
            r_hit     <= 1'b0;
            r_goal    <= 1'b0;
            r_respawn <= 1'b0;
            r_lives   <= 3'(LIVES);
            r_score   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hit     <= w_hit_nxt;
            r_goal    <= w_goal_nxt;
            r_respawn <= w_respawn_nxt;
            r_lives   <= w_lives_nxt;
            r_score   <= w_score_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_at_goal) begin
                    w_state_nxt = GOAL;
                end else if (w_risk) begin
                    w_state_nxt = HIT;
                end
            end
            HIT: begin
                if (w_flash_done) begin
                    w_state_nxt = (r_lives == 3'd0) ? OVER : RUN;
                end
            end
            // One dead cycle lets the respawn land before coordinates are trusted again.
            GOAL: w_state_nxt = RUN;
            OVER: w_state_nxt = OVER;
        endcase
    end

    always_comb begin
        w_goal_nxt    = (r_state == RUN) && w_at_goal;
        w_hit_nxt     = (r_state == RUN) && !w_at_goal && w_risk;
        w_respawn_nxt = w_goal_nxt ||
                        ((r_state == HIT) && w_flash_done && (r_lives != 3'd0));
        w_lives_nxt   = (w_hit_nxt && (r_lives != 3'd0)) ? r_lives - 3'd1 : r_lives;
        w_score_nxt   = (w_goal_nxt && (r_score != '1)) ? r_score + SCORE_W'(1) : r_score;
        w_blank       = 1'b0;
        case (r_state)
            HIT:     w_blank = w_flash_cnt[FLASH_W-1] ^ w_flash_cnt[FLASH_W-2];
            OVER:    w_blank = 1'b1;
            RUN:     w_blank = w_grace_blank;
            default: w_blank = 1'b0;
        endcase
    end

    assign bus.hit        = r_hit;
    assign bus.goal       = r_goal;
    assign bus.respawn    = r_respawn;
    assign bus.lives      = r_lives;
    assign bus.score      = r_score;
    assign bus.frog_blank = w_blank;
    assign bus.game_over  = (r_state == OVER);

endmodule

// File: tb/tb_frog_hazard_monitor.sv
// Directed game scenarios followed by random boards, all checked against a cycle-level game model.
module tb_frog_hazard_monitor;
    import frog_pkg::*;

    localparam int LIVES     = 3;
    localparam int FLASH_W   = 4;
    localparam int SCORE_W   = 8;
    localparam int FLASH_LEN = 1 << FLASH_W;
    localparam int GRACE_LEN = 1 << (FLASH_W - 1);
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
`ifdef FROG_GRACE_EN
    localparam bit GRACE_EN  = 1'b1;
`else
    localparam bit GRACE_EN  = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    frog_hazard_monitor_if #(.SCORE_W(SCORE_W)) bus ();

    frog_hazard_monitor #(
        .LIVES   (LIVES),
        .FLASH_W (FLASH_W),
        .SCORE_W (SCORE_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Game model: m_k counts cycles since the hit pulse (-1 when not flashing).
    int m_lives, m_score, m_k, m_grace;
    bit m_over, m_after_goal;
    bit e_hit, e_goal, e_respawn, e_blank;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit frog_in_danger();
        int  y;
        bit  lit;
        y   = int'(bus.frog_y);
        lit = bus.row_pixels[y][bus.frog_x];
        if (y == 0 || y == 15) return 1'b0;
        return bus.river_rows[y] ? !lit : lit;
    endfunction

    task automatic tick();
        bit grace_on;
        @(posedge clock);
        #1;
        e_hit     = 1'b0;
        e_goal    = 1'b0;
        e_respawn = 1'b0;
        if (reset) begin
            m_lives      = LIVES;
            m_score      = 0;
            m_k          = -1;
            m_grace      = 0;
            m_over       = 1'b0;
            m_after_goal = 1'b0;
        end else begin
            grace_on = GRACE_EN && (m_grace > 0);
            if (m_grace > 0) m_grace--;
            if (m_over) begin
                m_lives = 0;
            end else if (m_k >= 0) begin
                if (m_k == FLASH_LEN - 1) begin
                    m_k = -1;
                    if (m_lives == 0) begin
                        m_over = 1'b1;
                    end else begin
                        e_respawn = 1'b1;
                        m_grace   = GRACE_LEN;
                    end
                end else begin
                    m_k++;
                end
            end else if (m_after_goal) begin
                m_after_goal = 1'b0;
            end else if (bus.frog_y == 4'd15) begin
                e_goal       = 1'b1;
                e_respawn    = 1'b1;
                m_after_goal = 1'b1;
                m_grace      = GRACE_LEN;
                if (m_score < SCORE_MAX) m_score++;
            end else if (frog_in_danger() && !grace_on) begin
                e_hit = 1'b1;
                m_k   = 0;
                if (m_lives > 0) m_lives--;
            end
        end
        // Blink: first and last quarter of the flash show the frog, the middle half hides it.
        e_blank = m_over ? 1'b1 :
                  (m_k >= 0) ? (m_k >= FLASH_LEN / 4 && m_k < 3 * FLASH_LEN / 4) : 1'b0;

        check("hit",       bus.hit,       e_hit);
        check("goal",      bus.goal,      e_goal);
        check("respawn",   bus.respawn,   e_respawn);
        check("lives",     bus.lives,     m_lives);
        check("score",     bus.score,     m_score);
        check("game_over", bus.game_over, m_over);
        if (!(GRACE_EN && m_grace > 0 && m_k < 0 && !m_over))
            check("frog_blank", bus.frog_blank, e_blank);
    endtask

    task automatic place(input int x, input int y);
        bus.frog_x = 4'(x);
        bus.frog_y = 4'(y);
    endtask

    initial begin
        bus.row_pixels = '0;
        bus.river_rows = '0;
        place(int'(SPAWN_X), int'(START_ROW));

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Road hit, full flash, respawn, then immediate re-sample on the same lit cell.
        bus.row_pixels[3] = 16'h0010;
        place(4, 3);
        repeat (FLASH_LEN + 2) tick();
        place(int'(SPAWN_X), int'(START_ROW));
        repeat (FLASH_LEN + 2) tick();

        // River: log is safe, open water drowns; then reset at flash count 5.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.river_rows[8] = 1'b1;
        bus.row_pixels[8] = 16'h00F0;
        place(5, 8);
        repeat (3) tick();
        place(9, 8);
        tick();
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        place(int'(SPAWN_X), int'(START_ROW));
        repeat (3) tick();

        // Goal row with every pixel lit: score counts up and saturates.
        bus.row_pixels[15] = 16'hFFFF;
        place(2, 15);
        repeat (2 * (SCORE_MAX + 1) + 4) tick();
        place(int'(SPAWN_X), int'(START_ROW));
        repeat (2) tick();

        // Park on a lit road cell until the game ends, then try to provoke more events.
        place(4, 3);
        repeat (4 * FLASH_LEN + 4 * GRACE_LEN) tick();
        place(2, 15);
        repeat (5) tick();
        place(9, 8);
        repeat (3) tick();

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            if ($urandom_range(3) == 0) begin
                for (int y = 0; y < 16; y++) bus.row_pixels[y] = 16'($urandom);
                bus.river_rows = 16'($urandom);
            end
            place(int'($urandom_range(15)), int'($urandom_range(15)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
